// File: rtl/warp_scheduler.sv
// warp_scheduler
// Time-multiplexes a batch of THREADS 16-bit work items over LANES kernel
// instances. Each round it reads LANES/2 words from the host-to-FPGA FIFO,
// starts all lanes in parallel, gathers every lane result and writes
// LANES/2 result words to the FPGA-to-host FIFO.
//
// Ports
//   bus_clk, bus_rst_n          clock, asynchronous active-low reset
//   quiesce, session_open       host status; either one can force IDLE
//   in_rd_en/in_empty/in_data/in_valid     input FIFO (read latency 1)
//   out_wr_en/out_full/out_data            output FIFO
//   lane_in_data/lane_in_valid             operands and start pulse to lanes
//   lane_out_data/lane_out_valid           per-lane results and done pulses
//   busy, batch_done, timeout_err, round_idx  status
//
// state   | meaning
// IDLE    | waiting for an open, non-quiesced session with no error
// FETCH   | reading LANES/2 operand words from the input FIFO
// ISSUE   | one-cycle start pulse to every lane
// WAIT    | collecting one result per lane, watchdog running
// SEND    | writing LANES/2 result words to the output FIFO
// ERROR   | watchdog expired; held until the session is aborted
module warp_scheduler #(
   parameter int THREADS      = 256,
   parameter int LANES        = 16,
   parameter int EXEC_TIMEOUT = 4096,
   localparam int ROUNDS      = THREADS / LANES,
   localparam int RW          = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input  logic                  bus_clk,
   input  logic                  bus_rst_n,
   input  logic                  quiesce,
   input  logic                  session_open,
   output logic                  in_rd_en,
   input  logic                  in_empty,
   input  logic [31:0]           in_data,
   input  logic                  in_valid,
   output logic                  out_wr_en,
   input  logic                  out_full,
   output logic [31:0]           out_data,
   output logic [16*LANES-1:0]   lane_in_data,
   output logic [LANES-1:0]      lane_in_valid,
   input  logic [16*LANES-1:0]   lane_out_data,
   input  logic [LANES-1:0]      lane_out_valid,
   output logic                  busy,
   output logic                  batch_done,
   output logic                  timeout_err,
   output logic [RW-1:0]         round_idx
);

   localparam int HALF = LANES / 2;
   localparam int CW   = $clog2(HALF + 1);
   localparam int WW   = (EXEC_TIMEOUT > 0) ? $clog2(EXEC_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_SEND, S_ERROR
   } state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       req_cnt, rcv_cnt, snd_cnt;
   logic [WW-1:0]       wdog;
   logic [LANES-1:0]    done;
   logic [16*LANES-1:0] op_flat, res_flat;
   logic                abort, done_all, last_word, last_round, wd_expired;

   assign abort        = quiesce | ~session_open;
   // pulses arriving this cycle count toward completion so the last latch
   // and the move to SEND share a cycle
   assign done_all     = &(done | lane_out_valid);
   assign last_word    = (snd_cnt == CW'(HALF - 1));
   assign last_round   = (round_idx == RW'(ROUNDS - 1));
   assign wd_expired   = (EXEC_TIMEOUT != 0) && (wdog == WW'(EXEC_TIMEOUT - 1));
   assign busy         = (state != S_IDLE);
   assign lane_in_data = op_flat;

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      in_rd_en      = 1'b0;
      out_wr_en     = 1'b0;
      lane_in_valid = '0;
      batch_done    = 1'b0;
      out_data      = '0;
      for (int j = 0; j < HALF; j++)
         if (snd_cnt == CW'(j)) out_data = res_flat[32*j +: 32];
      case (state)
         S_IDLE:
            if (session_open && !quiesce && !timeout_err) state_nxt = S_FETCH;
         S_FETCH: begin
            in_rd_en = !in_empty && (req_cnt < CW'(HALF));
            if (in_valid && rcv_cnt == CW'(HALF - 1)) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            lane_in_valid = '1;
            state_nxt     = S_WAIT;
         end
         S_WAIT:
            if (done_all)        state_nxt = S_SEND;
            else if (wd_expired) state_nxt = S_ERROR;
         S_SEND: begin
            out_wr_en = !out_full;
            if (out_wr_en && last_word) begin
               if (last_round) begin
                  batch_done = 1'b1;
                  state_nxt  = S_IDLE;
               end else begin
                  state_nxt  = S_FETCH;
               end
            end
         end
         S_ERROR: state_nxt = S_ERROR;
         default: state_nxt = S_IDLE;
      endcase
      // no FIFO or lane side effects in the cycle the host pulls the session
      if (abort) begin
         state_nxt     = S_IDLE;
         in_rd_en      = 1'b0;
         out_wr_en     = 1'b0;
         lane_in_valid = '0;
         batch_done    = 1'b0;
      end
   end

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         req_cnt     <= '0;
         rcv_cnt     <= '0;
         snd_cnt     <= '0;
         wdog        <= '0;
         done        <= '0;
         op_flat     <= '0;
         res_flat    <= '0;
         timeout_err <= 1'b0;
         round_idx   <= '0;
      end else if (abort) begin
         req_cnt     <= '0;
         rcv_cnt     <= '0;
         snd_cnt     <= '0;
         wdog        <= '0;
         done        <= '0;
         timeout_err <= 1'b0;
         round_idx   <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (in_rd_en) req_cnt <= req_cnt + 1'b1;
               if (in_valid) begin
                  for (int k = 0; k < HALF; k++)
                     if (rcv_cnt == CW'(k)) op_flat[32*k +: 32] <= in_data;
                  rcv_cnt <= rcv_cnt + 1'b1;
               end
            end
            S_ISSUE: begin
               req_cnt <= '0;
               rcv_cnt <= '0;
               done    <= '0;
               wdog    <= '0;
            end
            S_WAIT: begin
               for (int i = 0; i < LANES; i++)
                  if (lane_out_valid[i] && !done[i])
                     res_flat[16*i +: 16] <= lane_out_data[16*i +: 16];
               done <= done | lane_out_valid;
               if (EXEC_TIMEOUT != 0) wdog <= wdog + 1'b1;
               if (!done_all && wd_expired) timeout_err <= 1'b1;
            end
            S_SEND: begin
               if (out_wr_en) begin
                  if (last_word) begin
                     snd_cnt   <= '0;
                     round_idx <= last_round ? '0 : round_idx + 1'b1;
                  end else begin
                     snd_cnt   <= snd_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Time-multiplexes a batch of THREADS 16-bit work items over a smaller array of LANES kernel instances, all on bus_clk.
- Per round it fetches LANES items from the host-to-FPGA FIFO and issues them to the lanes in parallel. It then collects every lane result and writes the results to the FPGA-to-host FIFO.
- Sits between the two 32x512 Xillybus FIFOs and the kernel lane array, replacing the one-kernel-per-thread warp.

Parameters:
THREADS, 256, work items per batch; even, multiple of LANES.
LANES, 16, kernel instances driven; even, >=2.
EXEC_TIMEOUT, 4096, max WAIT cycles per round before error; 0 disables the watchdog.

Ports:
bus_clk  in  1  system clock (PCIe bus clock)
bus_rst_n  in  1  asynchronous active-low reset
quiesce  in  1  host driver not loaded; forces IDLE
session_open  in  1  high while both host device files are open
in_rd_en  out  1  read strobe to input FIFO
in_empty  in  1  input FIFO empty
in_data  in  32  input word; [15:0] = even item, [31:16] = odd item
in_valid  in  1  in_data valid, one cycle after an accepted in_rd_en
out_wr_en  out  1  write strobe to output FIFO
out_full  in  1  output FIFO full
out_data  out  32  result word; [15:0] = even lane, [31:16] = odd lane
lane_in_data  out  16*LANES  operand per lane; lane i uses bits [16i+15:16i]
lane_in_valid  out  LANES  one-cycle start pulse per lane
lane_out_data  in  16*LANES  result per lane
lane_out_valid  in  LANES  one-cycle result pulse per lane; arbitrary latency >=1
busy  out  1  high in any state other than IDLE
batch_done  out  1  one-cycle pulse when the last result word of a batch is written
timeout_err  out  1  sticky watchdog error flag
round_idx  out  clog2(THREADS/LANES)  current round number

Behaviour:
- Reset (async, bus_rst_n low): state=IDLE. All outputs 0, all counters 0, operand/result registers 0, done mask 0.
- Abort: if quiesce=1 or session_open=0, next state is IDLE regardless of current state. Counters and done mask clear. Any in-flight lane results are discarded. timeout_err clears only on this abort or on reset.
- States:
  - IDLE -> FETCH when session_open=1, quiesce=0 and timeout_err=0.
  - FETCH: in_rd_en = !in_empty && req_cnt < LANES/2; req_cnt increments on each asserted in_rd_en. Each in_valid stores word k = rcv_cnt into lanes 2k (low half) and 2k+1 (high half); rcv_cnt++. -> ISSUE when rcv_cnt reaches LANES/2.
  - ISSUE: exactly one cycle. lane_in_valid = all ones; lane_in_data holds the operands. Done mask and watchdog clear. -> WAIT.
  - WAIT: lane_out_valid[i] with done[i]=0 latches lane_out_data[i] and sets done[i]. A pulse on an already-done lane is ignored. Multiple lanes may complete in the same cycle. -> SEND when the mask is all ones; the last latch and the transition may occur in the same cycle. If EXEC_TIMEOUT!=0 and the watchdog reaches EXEC_TIMEOUT first -> ERROR.
  - SEND: out_data = {res[2j+1], res[2j]} for word j = snd_cnt; out_wr_en = !out_full; snd_cnt++ on each write. After word LANES/2-1 is written: if round_idx = THREADS/LANES-1, pulse batch_done and go to IDLE with round_idx=0; else round_idx++ and go to FETCH.
  - ERROR: timeout_err=1; all strobes low; held until abort or reset.
- lane_out_valid outside WAIT is ignored. in_rd_en is never asserted outside FETCH. out_wr_en is never asserted while out_full=1.
- Timing: ISSUE is 1 cycle. FETCH takes >= LANES/2+1 cycles with a non-empty FIFO, since read latency is 1. SEND takes >= LANES/2 cycles. Minimum round time is LANES+2+kernel latency cycles.
- Widths: all counters are sized exactly and never wrap within a round. Results pass through unmodified (no arithmetic).

Test Plan:
- Defaults, FIFO preloaded with 128 words (item value = index), kernels return x+1 with latency 3 -> 128 output words, word 0 = 0x0002_0001, 16 rounds, single batch_done pulse, busy falls the cycle after.
- in_empty toggles every other cycle during FETCH -> in_rd_en never high while empty; operands still land on the correct lanes.
- Lanes complete in reverse order, and lane 5 pulses twice -> first result kept; SEND begins only after lane 0 completes.
- out_full held high for 10 cycles mid-SEND -> no out_wr_en during the stall; word order and values unchanged afterwards.
- EXEC_TIMEOUT=8, lane 3 never responds -> ERROR after 8 WAIT cycles, timeout_err=1; the flag clears only when session_open drops.
- session_open dropped during WAIT of round 4, then re-raised -> IDLE the next cycle; new batch starts at round_idx=0; bus_rst_n asserted mid-SEND zeroes outputs immediately, without waiting for a clock edge.
